rf_dbg_master: RTL and testbench
================================

# rf_dbg_master

Command-driven initiator for the 8×8 register file's write port 3, move port 4 and read port 1. It accepts read, write, move and dump commands over a valid/ready handshake and sequences the register-file control lines. Read data comes back over a second valid/ready response channel. It sits between the lab debug/loader interface and the register file; an external mux selects it instead of the datapath.

## Interface
Parameters:
- NREG, 8, number of registers addressed.
- DW, 8, data width.
- AW, 3, address width, equal to $clog2(NREG).

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  command opcode: RD=0, WR=1, MOV=2, DUMP=3.
- cmd_dst  in  AW  destination register for WR/MOV.
- cmd_src  in  AW  source register for RD/MOV.
- cmd_data  in  DW  write data for WR.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DW  register value.
- rsp_addr  out  AW  register index of rsp_data.
- rsp_last  out  1  final response of the command.
- busy  out  1  high whenever the FSM is not in IDLE.
- rf_we3, rf_we4  out  1  write enables for port 3 and port 4.
- rf_ra1  out  AW  read address for port 1.
- rf_wa3, rf_wa4  out  AW  write addresses for port 3 and port 4.
- rf_wd3  out  DW  write data for port 3.
- rf_rd1  in  DW  combinational read data from port 1.

## Operation
- States: IDLE, EXEC, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/dst/src/data, clear idx, go to EXEC.
- EXEC, one cycle:
  - WR: rf_we3=1, rf_wa3=dst, rf_wd3=data, then go to IDLE. No response.
  - MOV: rf_ra1=src, rf_wa4=dst, rf_we4=1, then go to IDLE. No response.
  - RD: rf_ra1=src. Register rf_rd1 into rsp_data and src into rsp_addr; set rsp_last=1; go to RSP.
  - DUMP: rf_ra1=idx. Capture rf_rd1 into rsp_data and idx into rsp_addr; rsp_last=(idx==NREG-1); go to RSP.
- RSP: rsp_valid=1. On rsp_ready:
  - if rsp_last, go to IDLE;
  - otherwise idx++ and go to EXEC (DUMP only).
- rf_we3 and rf_we4 are never asserted together. Neither is asserted outside EXEC.
- Unused rf address/data outputs hold their latched values. They carry no meaning while the enables are low.
- idx is AW+1 bits wide, so the comparison against NREG-1 never wraps.

## Timing
- Reset values: cmd_ready=1 (IDLE), busy=0, rsp_valid=0, rsp_last=0, rsp_data=0, rsp_addr=0, rf_we3=0, rf_we4=0, all rf addresses and rf_wd3 = 0, idx=0.
- An accept at edge E0 puts the block in EXEC for the cycle after E0.
  - WR/MOV: the register file updates at E1. cmd_ready returns after E1. Throughput is one WR/MOV per 2 cycles.
  - RD: rsp_valid rises after E1. With rsp_ready held high, the response completes at E2.
  - DUMP with rsp_ready held high takes 2·NREG cycles from E0 to the return to IDLE.
- The response channel holds rsp_valid, rsp_data, rsp_addr and rsp_last stable until rsp_ready is seen. Backpressure stalls the FSM in RSP indefinitely.
- A command accepted right after a WR to the same register observes the new value, because EXEC reads after the write edge.
- MOV with src==dst rewrites the same value. This is legal.
- Reset asserted mid-command is asynchronous:
  - rf_we3, rf_we4 and rsp_valid drop immediately;
  - the FSM returns to IDLE and the command is lost;
  - a partially completed DUMP is not resumed.
- cmd_* inputs are ignored while cmd_ready=0.

## Structure
- Package rf_dbg_pkg holds:
  - op_e enum (RD, WR, MOV, DUMP);
  - state_e enum (IDLE, EXEC, RSP);
  - localparams NREG, DW and AW shared with the register-file instantiation.
- Single module, no sub-module. The idx counter and FSM are inline.

## Test plan
- WR dst=5 data=8'hA7, then RD src=5: exactly one rf_we3 pulse with wa3=5; rsp_data=8'hA7, rsp_addr=5, rsp_last=1 after E1.
- WR r2=8'h3C, MOV src=2 dst=6, RD src=6: exactly one rf_we4 pulse with ra1=2, wa4=6; read returns 8'h3C.
- Preload r0..r7 with 8'h10..8'h17, then DUMP with rsp_ready toggling randomly: 8 responses with addr 0..7 and data 8'h10..8'h17, rsp_last only on addr 7, outputs stable while stalled.
- Back-to-back WR commands with cmd_valid held high: accepts exactly every 2nd cycle, we3 never high in two consecutive cycles.
- Assert reset_n=0 during the DUMP response at addr 3: rsp_valid and busy go to 0 asynchronously. After release cmd_ready=1, and a new RD completes normally.
- Drive cmd_valid with an RD while busy in DUMP: command not accepted, no extra response, DUMP sequence unchanged.

Source files
------------

// File: rtl/rf_dbg_pkg.sv
// Shared types and sizing for the register-file debug master and the register file it drives.
package rf_dbg_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    RD   = 2'd0,
    WR   = 2'd1,
    MOV  = 2'd2,
    DUMP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/rf_dbg_master.sv
// Command-driven initiator for register-file write port 3, move port 4 and read port 1.
// Executes RD/WR/MOV/DUMP commands and returns read data over a valid/ready response channel.
module rf_dbg_master #(
  parameter int unsigned NREG = rf_dbg_pkg::NREG,
  parameter int unsigned DW   = rf_dbg_pkg::DW,
  parameter int unsigned AW   = rf_dbg_pkg::AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          busy,
  output logic          rf_we3,
  output logic          rf_we4,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_wa3,
  output logic [AW-1:0] rf_wa4,
  output logic [DW-1:0] rf_wd3,
  input  logic [DW-1:0] rf_rd1
);
  import rf_dbg_pkg::*;

  localparam int unsigned IW = AW + 1;

  state_e        state_q;
  state_e        state_d;
  op_e           op_q;
  logic [IW-1:0] idx_q;
  logic          accept_c;
  logic          reads_c;

  assign reads_c = (op_q == RD) || (op_q == DUMP);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept_c = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC:    state_d = reads_c ? RSP : IDLE;
      RSP: begin
        if (rsp_ready) begin
          state_d = rsp_last ? IDLE : EXEC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      rsp_valid <= (state_d == RSP);
    end
  end

  // Command latch, register-file drive and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= RD;
      idx_q    <= '0;
      rf_we3   <= 1'b0;
      rf_we4   <= 1'b0;
      rf_ra1   <= '0;
      rf_wa3   <= '0;
      rf_wa4   <= '0;
      rf_wd3   <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
      rsp_last <= 1'b0;
    end else begin
      rf_we3 <= 1'b0;
      rf_we4 <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q  <= op_e'(cmd_op);
            idx_q <= '0;
            case (op_e'(cmd_op))
              WR: begin
                rf_we3 <= 1'b1;
                rf_wa3 <= cmd_dst;
                rf_wd3 <= cmd_data;
              end
              MOV: begin
                rf_we4 <= 1'b1;
                rf_wa4 <= cmd_dst;
                rf_ra1 <= cmd_src;
              end
              RD:      rf_ra1 <= cmd_src;
              default: rf_ra1 <= '0;
            endcase
          end
        end
        EXEC: begin
          if (reads_c) begin
            rsp_data <= rf_rd1;
            rsp_addr <= rf_ra1;
            rsp_last <= (op_q == RD) || (idx_q == IW'(NREG - 1));
          end
        end
        RSP: begin
          // Only a DUMP can be in RSP without rsp_last; step to the next register
          if (rsp_ready && !rsp_last) begin
            idx_q  <= idx_q + IW'(1);
            rf_ra1 <= AW'(idx_q + IW'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dbg_master.sv
// Self-checking bench for rf_dbg_master with a behavioural 8x8 register file and response scoreboard.
module tb_rf_dbg_master;
  import rf_dbg_pkg::*;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_addr;
  logic       rsp_last;
  logic       busy;
  logic       rf_we3;
  logic       rf_we4;
  logic [2:0] rf_ra1;
  logic [2:0] rf_wa3;
  logic [2:0] rf_wa4;
  logic [7:0] rf_wd3;
  logic [7:0] rf_rd1;

  logic [7:0] rf_mem [8];
  logic [7:0] shadow [8];
  exp_t       exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;
  int we3_cnt, we4_cnt, rsp_cnt, acc_cyc, last_rsp_cyc;
  logic       prev_we3 = 1'b0;
  logic       stalled = 1'b0;
  logic [7:0] h_data;
  logic [2:0] h_addr;
  logic       h_last;
  logic [2:0] last_wa3, mov_ra1, mov_wa4;
  logic [7:0] last_wd3;

  always #5 clk = ~clk;

  rf_dbg_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy),
    .rf_we3(rf_we3), .rf_we4(rf_we4), .rf_ra1(rf_ra1),
    .rf_wa3(rf_wa3), .rf_wa4(rf_wa4), .rf_wd3(rf_wd3), .rf_rd1(rf_rd1)
  );

  // Register file: combinational read port 1, write port 3, move port 4 fed from port 1
  assign rf_rd1 = rf_mem[rf_ra1];
  always_ff @(posedge clk) begin
    if (rf_we3) rf_mem[rf_wa3] <= rf_wd3;
    if (rf_we4) rf_mem[rf_wa4] <= rf_mem[rf_ra1];
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

  // One clock of observation: write-enable monitors, response stability, scoreboard pop.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rf_we3 || rf_we4) begin
      checks++;
      if (rf_we3 && rf_we4) begin
        errors++;
        $display("FAIL we_overlap: we3=%0b we4=%0b, required not both high", rf_we3, rf_we4);
      end
    end
    if (rf_we3) begin
      we3_cnt++;
      last_wa3 = rf_wa3;
      last_wd3 = rf_wd3;
      checks++;
      if (prev_we3) begin
        errors++;
        $display("FAIL we3_consecutive: we3 high two cycles in a row at cycle %0d", cyc);
      end
    end
    prev_we3 = rf_we3;
    if (rf_we4) begin
      we4_cnt++;
      mov_ra1 = rf_ra1;
      mov_wa4 = rf_wa4;
    end
    if (stalled) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== h_data || rsp_addr !== h_addr || rsp_last !== h_last) begin
        errors++;
        $display("FAIL rsp_stable: got v=%0b d=%h a=%0d l=%0b, held d=%h a=%0d l=%0b",
                 rsp_valid, rsp_data, rsp_addr, rsp_last, h_data, h_addr, h_last);
      end
    end
    case (ready_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (rsp_valid && rsp_ready) begin
      last_rsp_cyc = cyc;
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: d=%h a=%0d l=%0b with nothing expected", rsp_data, rsp_addr, rsp_last);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_addr, rsp_data, rsp_last} !== e) begin
          errors++;
          $display("FAIL rsp: got a=%0d d=%h l=%0b, expected a=%0d d=%h l=%0b",
                   rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
        end
      end
    end
    stalled = rsp_valid && !rsp_ready;
    h_data  = rsp_data;
    h_addr  = rsp_addr;
    h_last  = rsp_last;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [7:0] d, input logic l);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Present a command until accepted; update the reference model at the accepting edge.
  task automatic send_cmd(input op_e op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [7:0] data, input bit keep);
    int  n = 0;
    bit  acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    cmd_data  = data;
    while (!acc && n < 200) begin
      acc = cmd_ready;
      tick();
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cmd_accept: op=%0d not accepted within %0d cycles", op, n);
    end
    acc_cyc = cyc;
    if (!keep) cmd_valid = 1'b0;
    case (op)
      WR:  shadow[dst] = data;
      MOV: shadow[dst] = shadow[src];
      RD:  push_exp(src, shadow[src], 1'b1);
      default: for (int i = 0; i < 8; i++) push_exp(3'(i), shadow[i], i == 7);
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, busy=%0b", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_dst   = 3'd0;
    cmd_src   = 3'd0;
    cmd_data  = 8'd0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b busy=%0b rsp_valid=%0b rsp_last=%0b, required 1 0 0 0",
               cmd_ready, busy, rsp_valid, rsp_last);
    end
    checks++;
    if (rsp_data !== 8'h00 || rsp_addr !== 3'd0 || rf_we3 !== 1'b0 || rf_we4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: d=%h a=%0d we3=%0b we4=%0b, required zeros", rsp_data, rsp_addr, rf_we3, rf_we4);
    end
    checks++;
    if (rf_ra1 !== 3'd0 || rf_wa3 !== 3'd0 || rf_wa4 !== 3'd0 || rf_wd3 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rf: ra1=%0d wa3=%0d wa4=%0d wd3=%h, required zeros", rf_ra1, rf_wa3, rf_wa4, rf_wd3);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_wr_rd();
    we3_cnt = 0;
    send_cmd(WR, 3'd5, 3'd0, 8'hA7, 1'b0);
    send_cmd(RD, 3'd0, 3'd5, 8'h00, 1'b0);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_exec: rsp_valid=%0b busy=%0b during EXEC, required 0 1", rsp_valid, busy);
    end
    drain();
    checks++;
    if (last_rsp_cyc != acc_cyc + 1) begin
      errors++;
      $display("FAIL rd_latency: response at cycle %0d, required %0d", last_rsp_cyc, acc_cyc + 1);
    end
    checks++;
    if (we3_cnt != 1 || last_wa3 !== 3'd5 || last_wd3 !== 8'hA7) begin
      errors++;
      $display("FAIL wr_pulse: count=%0d wa3=%0d wd3=%h, required 1 5 a7", we3_cnt, last_wa3, last_wd3);
    end
  endtask

  task automatic test_mov();
    we4_cnt = 0;
    send_cmd(WR, 3'd2, 3'd0, 8'h3C, 1'b0);
    send_cmd(MOV, 3'd6, 3'd2, 8'h00, 1'b0);
    send_cmd(RD, 3'd0, 3'd6, 8'h00, 1'b0);
    drain();
    checks++;
    if (we4_cnt != 1 || mov_ra1 !== 3'd2 || mov_wa4 !== 3'd6) begin
      errors++;
      $display("FAIL mov_pulse: count=%0d ra1=%0d wa4=%0d, required 1 2 6", we4_cnt, mov_ra1, mov_wa4);
    end
    send_cmd(MOV, 3'd6, 3'd6, 8'h00, 1'b0);
    send_cmd(RD, 3'd0, 3'd6, 8'h00, 1'b0);
    drain();
  endtask

  task automatic test_dump();
    int n0;
    int n = 0;
    for (int i = 0; i < 8; i++) send_cmd(WR, 3'(i), 3'd0, 8'(8'h10 + i), 1'b0);
    ready_mode = 2;
    n0 = rsp_cnt;
    send_cmd(DUMP, 3'd0, 3'd0, 8'h00, 1'b0);
    drain();
    checks++;
    if (rsp_cnt - n0 != 8) begin
      errors++;
      $display("FAIL dump_count: got %0d responses, required 8", rsp_cnt - n0);
    end
    ready_mode = 1;
    send_cmd(DUMP, 3'd0, 3'd0, 8'h00, 1'b0);
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (cyc - acc_cyc != 16) begin
      errors++;
      $display("FAIL dump_cycles: took %0d cycles, required 16", cyc - acc_cyc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int prev;
    we3_cnt = 0;
    send_cmd(WR, 3'd1, 3'd0, 8'h51, 1'b1);
    for (int i = 0; i < 3; i++) begin
      prev = acc_cyc;
      send_cmd(WR, 3'(2 + i), 3'd0, 8'(8'h60 + i), i != 2);
      checks++;
      if (acc_cyc - prev != 2) begin
        errors++;
        $display("FAIL b2b_spacing: accept gap %0d cycles, required 2", acc_cyc - prev);
      end
    end
    drain();
    checks++;
    if (we3_cnt != 4) begin
      errors++;
      $display("FAIL b2b_count: we3 pulses %0d, required 4", we3_cnt);
    end
  endtask

  task automatic test_busy_ignore();
    int n0;
    int n = 0;
    ready_mode = 2;
    n0 = rsp_cnt;
    send_cmd(DUMP, 3'd0, 3'd0, 8'h00, 1'b0);
    while (n < 200) begin
      if (!busy) break;
      cmd_valid = 1'b1;
      cmd_op    = RD;
      cmd_src   = 3'd1;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    drain();
    repeat (4) tick();
    checks++;
    if (rsp_cnt - n0 != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore: %0d responses, %0d pending, required 8 0", rsp_cnt - n0, exp_q.size());
    end
    ready_mode = 1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ready_mode = 1;
    send_cmd(DUMP, 3'd0, 3'd0, 8'h00, 1'b0);
    while (!(rsp_valid && rsp_addr == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reset_mid_wait: addr 3 response not seen");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rf_we3 !== 1'b0 || rf_we4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rsp_valid=%0b busy=%0b we3=%0b we4=%0b, required zeros",
               rsp_valid, busy, rf_we3, rf_we4);
    end
    exp_q.delete();
    stalled = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b busy=%0b rsp_valid=%0b, required 1 0 0",
               cmd_ready, busy, rsp_valid);
    end
    send_cmd(RD, 3'd0, 3'd3, 8'h00, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_mov();
    test_dump();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
